// File: rtl/VX_ag_tcu_pkg.sv
// Shared types and widths for the TCU macro-op issue sequencer.
package VX_ag_tcu_pkg;

    localparam int TCU_SCALE_W = 9;
    localparam int TCU_STEP_W  = 4;
    localparam int TCU_IDX_W   = 2 * TCU_STEP_W;

    typedef enum logic [1:0] {
        TCU_IDLE  = 2'd0,
        TCU_DRAIN = 2'd1,
        TCU_ISSUE = 2'd2
    } tcu_state_e;

    // Linear micro-op index for step (m, n) with m outer and n inner.
    function automatic logic [TCU_IDX_W-1:0] tcu_step_index(
        input logic [TCU_STEP_W-1:0] m,
        input logic [TCU_STEP_W-1:0] n,
        input logic [TCU_STEP_W-1:0] n_cnt
    );
        return TCU_IDX_W'(m) * (TCU_IDX_W'(n_cnt) + TCU_IDX_W'(1)) + TCU_IDX_W'(n);
    endfunction

endpackage

// File: rtl/VX_gpu_pkg.sv
// Machine-wide widths shared by the GPU core blocks.
package VX_gpu_pkg;

    localparam int UUID_WIDTH    = 44;
    localparam int NW_WIDTH      = 4;
    localparam int PC_BITS       = 32;
    localparam int NUM_REGS_BITS = 6;

endpackage

// File: rtl/VX_ag_tcu_step_counter.sv
// Nested m/n step counter: n is the inner loop, wraps to (0,0) after the last step.
module VX_ag_tcu_step_counter
    import VX_ag_tcu_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  advance_i,
    input  logic [TCU_STEP_W-1:0] m_cnt_i,
    input  logic [TCU_STEP_W-1:0] n_cnt_i,
    output logic [TCU_STEP_W-1:0] step_m_o,
    output logic [TCU_STEP_W-1:0] step_n_o,
    output logic                  last_o
);

    logic [TCU_STEP_W-1:0] m_q, m_d;
    logic [TCU_STEP_W-1:0] n_q, n_d;
    logic                  m_end, n_end;

    assign m_end    = (m_q == m_cnt_i);
    assign n_end    = (n_q == n_cnt_i);
    assign last_o   = m_end && n_end;
    assign step_m_o = m_q;
    assign step_n_o = n_q;

    always_comb begin
        m_d = m_q;
        n_d = n_q;
        if (clear_i) begin
            m_d = '0;
            n_d = '0;
        end else if (advance_i) begin
            if (n_end) begin
                n_d = '0;
                m_d = m_end ? '0 : m_q + TCU_STEP_W'(1);
            end else begin
                n_d = n_q + TCU_STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q <= '0;
            n_q <= '0;
        end else begin
            m_q <= m_d;
            n_q <= n_d;
        end
    end

endmodule

// File: rtl/vx_ag_tcu_issue_seq.sv
// Expands one TCU macro-op into an m x n sequence of micro-ops, bounding the number
// in flight and only switching the block scale once every older micro-op has retired.
module vx_ag_tcu_issue_seq
    import VX_gpu_pkg::*;
    import VX_ag_tcu_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [UUID_WIDTH-1:0]    req_uuid,
    input  logic [NW_WIDTH-1:0]      req_wid,
    input  logic [PC_BITS-1:0]       req_PC,
    input  logic [NUM_REGS_BITS-1:0] req_rd,
    input  logic [TCU_STEP_W-1:0]    req_m_cnt,
    input  logic [TCU_STEP_W-1:0]    req_n_cnt,
    input  logic [3:0]               req_fmt_s,
    input  logic [3:0]               req_fmt_d,
    input  logic [TCU_SCALE_W-1:0]   req_scale,

    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic [UUID_WIDTH-1:0]    uop_uuid,
    output logic [NW_WIDTH-1:0]      uop_wid,
    output logic [PC_BITS-1:0]       uop_PC,
    output logic [NUM_REGS_BITS-1:0] uop_rd,
    output logic [TCU_STEP_W-1:0]    uop_step_m,
    output logic [TCU_STEP_W-1:0]    uop_step_n,
    output logic [3:0]               uop_fmt_s,
    output logic [3:0]               uop_fmt_d,
    output logic                     uop_last,

    input  logic                     retire,
    output logic [TCU_SCALE_W-1:0]   scale_combined,
    output logic                     busy,
    output logic                     done,
    output logic                     err_underflow
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    tcu_state_e state_q, state_d;

    logic [UUID_WIDTH-1:0]    uuid_q;
    logic [NW_WIDTH-1:0]      wid_q;
    logic [PC_BITS-1:0]       pc_q;
    logic [NUM_REGS_BITS-1:0] rd_q;
    logic [TCU_STEP_W-1:0]    m_cnt_q;
    logic [TCU_STEP_W-1:0]    n_cnt_q;
    logic [3:0]               fmt_s_q;
    logic [3:0]               fmt_d_q;
    logic [TCU_SCALE_W-1:0]   pend_scale_q;

    logic [TCU_SCALE_W-1:0]   scale_q, scale_d;
    logic [CNT_W-1:0]         inflight_q, inflight_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;

    logic                     req_accept;
    logic                     uop_fire;
    logic                     retire_ok;
    logic                     inflight_zero;
    logic [TCU_STEP_W-1:0]    step_m, step_n;
    logic                     step_last;

    assign inflight_zero = (inflight_q == '0);
    assign req_ready     = (state_q == TCU_IDLE);
    assign req_accept    = req_valid && req_ready;
    assign uop_valid     = (state_q == TCU_ISSUE) && (inflight_q < CNT_W'(MAX_INFLIGHT));
    assign uop_fire      = uop_valid && uop_ready;
    assign retire_ok     = retire && !inflight_zero;

    VX_ag_tcu_step_counter u_step (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (req_accept),
        .advance_i (uop_fire),
        .m_cnt_i   (m_cnt_q),
        .n_cnt_i   (n_cnt_q),
        .step_m_o  (step_m),
        .step_n_o  (step_n),
        .last_o    (step_last)
    );

    always_comb begin
        state_d = state_q;
        scale_d = scale_q;
        done_d  = 1'b0;
        case (state_q)
            TCU_IDLE: begin
                if (req_accept) begin
                    // Scale may only switch with nothing in flight; equal scale needs no drain.
                    if ((req_scale == scale_q) || inflight_zero) begin
                        scale_d = req_scale;
                        state_d = TCU_ISSUE;
                    end else begin
                        state_d = TCU_DRAIN;
                    end
                end
            end
            TCU_DRAIN: begin
                if (inflight_zero) begin
                    scale_d = pend_scale_q;
                    state_d = TCU_ISSUE;
                end
            end
            TCU_ISSUE: begin
                if (uop_fire && step_last) begin
                    done_d  = 1'b1;
                    state_d = TCU_IDLE;
                end
            end
            default: state_d = TCU_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q + CNT_W'(uop_fire) - CNT_W'(retire_ok);
        err_d      = err_q | (retire && inflight_zero);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= TCU_IDLE;
            scale_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uuid_q       <= '0;
            wid_q        <= '0;
            pc_q         <= '0;
            rd_q         <= '0;
            m_cnt_q      <= '0;
            n_cnt_q      <= '0;
            fmt_s_q      <= '0;
            fmt_d_q      <= '0;
            pend_scale_q <= '0;
        end else if (req_accept) begin
            uuid_q       <= req_uuid;
            wid_q        <= req_wid;
            pc_q         <= req_PC;
            rd_q         <= req_rd;
            m_cnt_q      <= req_m_cnt;
            n_cnt_q      <= req_n_cnt;
            fmt_s_q      <= req_fmt_s;
            fmt_d_q      <= req_fmt_d;
            pend_scale_q <= req_scale;
        end
    end

    assign uop_uuid       = uuid_q;
    assign uop_wid        = wid_q;
    assign uop_PC         = pc_q;
    assign uop_rd         = rd_q + NUM_REGS_BITS'(tcu_step_index(step_m, step_n, n_cnt_q));
    assign uop_step_m     = step_m;
    assign uop_step_n     = step_n;
    assign uop_fmt_s      = fmt_s_q;
    assign uop_fmt_d      = fmt_d_q;
    assign uop_last       = step_last;

    assign scale_combined = scale_q;
    assign busy           = (state_q != TCU_IDLE) || !inflight_zero;
    assign done           = done_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_vx_ag_tcu_issue_seq.sv
// Bench for the TCU issue sequencer: queue-based reference model compared every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_vx_ag_tcu_issue_seq;
    import VX_gpu_pkg::*;
    import VX_ag_tcu_pkg::*;

    localparam int MAXI = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic                     req_valid, req_ready;
    logic [UUID_WIDTH-1:0]    req_uuid;
    logic [NW_WIDTH-1:0]      req_wid;
    logic [PC_BITS-1:0]       req_PC;
    logic [NUM_REGS_BITS-1:0] req_rd;
    logic [3:0]               req_m_cnt, req_n_cnt, req_fmt_s, req_fmt_d;
    logic [8:0]               req_scale;
    logic                     uop_valid, uop_ready;
    logic [UUID_WIDTH-1:0]    uop_uuid;
    logic [NW_WIDTH-1:0]      uop_wid;
    logic [PC_BITS-1:0]       uop_PC;
    logic [NUM_REGS_BITS-1:0] uop_rd;
    logic [3:0]               uop_step_m, uop_step_n, uop_fmt_s, uop_fmt_d;
    logic                     uop_last, retire, busy, done, err_underflow;
    logic [8:0]               scale_combined;

    vx_ag_tcu_issue_seq #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
        .req_wid(req_wid), .req_PC(req_PC), .req_rd(req_rd),
        .req_m_cnt(req_m_cnt), .req_n_cnt(req_n_cnt),
        .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_scale(req_scale),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_uuid(uop_uuid),
        .uop_wid(uop_wid), .uop_PC(uop_PC), .uop_rd(uop_rd),
        .uop_step_m(uop_step_m), .uop_step_n(uop_step_n),
        .uop_fmt_s(uop_fmt_s), .uop_fmt_d(uop_fmt_d), .uop_last(uop_last),
        .retire(retire), .scale_combined(scale_combined), .busy(busy),
        .done(done), .err_underflow(err_underflow)
    );

    typedef struct {
        logic [UUID_WIDTH-1:0]    uuid;
        logic [NW_WIDTH-1:0]      wid;
        logic [PC_BITS-1:0]       pc;
        logic [NUM_REGS_BITS-1:0] rd;
        logic [3:0]               sm, sn, fs, fd;
        logic                     last;
    } uop_t;

    // Model: phase 0 = accepting, 1 = waiting for in-flight work to empty, 2 = issuing.
    uop_t mq[$];
    int   md_phase, md_infl, md_scale, md_pend_scale;
    bit   md_err, md_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [NUM_REGS_BITS-1:0] log_rd[$];
    logic [3:0]               log_m[$], log_n[$];
    logic                     log_last[$];
    int                       log_cyc[$];
    int                       done_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_all();
        bit ev;
        ev = (md_phase == 2) && (md_infl < MAXI);
        chk("req_ready", req_ready, md_phase == 0);
        chk("uop_valid", uop_valid, ev);
        chk("busy", busy, (md_phase != 0) || (md_infl != 0));
        chk("done", done, md_done);
        chk("err_underflow", err_underflow, md_err);
        chk("scale_combined", scale_combined, md_scale);
        if (ev && uop_valid && mq.size() > 0) begin
            chk("uop_uuid", uop_uuid, mq[0].uuid);
            chk("uop_wid", uop_wid, mq[0].wid);
            chk("uop_PC", uop_PC, mq[0].pc);
            chk("uop_rd", uop_rd, mq[0].rd);
            chk("uop_step_m", uop_step_m, mq[0].sm);
            chk("uop_step_n", uop_step_n, mq[0].sn);
            chk("uop_fmt_s", uop_fmt_s, mq[0].fs);
            chk("uop_fmt_d", uop_fmt_d, mq[0].fd);
            chk("uop_last", uop_last, mq[0].last);
        end
    endtask

    task automatic model_update();
        bit   ev, acc_u;
        int   infl0, k;
        uop_t u;
        if (reset) begin
            md_phase = 0; md_infl = 0; md_scale = 0; md_err = 0; md_done = 0;
            mq.delete();
            return;
        end
        ev    = (md_phase == 2) && (md_infl < MAXI);
        acc_u = ev && uop_ready;
        infl0 = md_infl;
        md_done = 0;
        case (md_phase)
            0: if (req_valid) begin
                mq.delete();
                k = 0;
                for (int m = 0; m <= int'(req_m_cnt); m++) begin
                    for (int n = 0; n <= int'(req_n_cnt); n++) begin
                        u.uuid = req_uuid; u.wid = req_wid; u.pc = req_PC;
                        u.rd = req_rd + NUM_REGS_BITS'(k);
                        u.sm = 4'(m); u.sn = 4'(n);
                        u.fs = req_fmt_s; u.fd = req_fmt_d;
                        u.last = (m == int'(req_m_cnt)) && (n == int'(req_n_cnt));
                        mq.push_back(u);
                        k++;
                    end
                end
                md_pend_scale = int'(req_scale);
                if (int'(req_scale) == md_scale || infl0 == 0) begin
                    md_scale = int'(req_scale);
                    md_phase = 2;
                end else begin
                    md_phase = 1;
                end
            end
            1: if (infl0 == 0) begin
                md_scale = md_pend_scale;
                md_phase = 2;
            end
            default: if (acc_u) begin
                u = mq.pop_front();
                if (u.last) begin
                    md_done  = 1;
                    md_phase = 0;
                end
            end
        endcase
        if (acc_u) md_infl++;
        if (retire) begin
            if (infl0 == 0) md_err = 1;
            else md_infl--;
        end
    endtask

    task automatic step();
        if (!reset && uop_valid && uop_ready) begin
            log_rd.push_back(uop_rd); log_m.push_back(uop_step_m);
            log_n.push_back(uop_step_n); log_last.push_back(uop_last);
            log_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare_all();
        if (done) done_cyc.push_back(cyc);
    endtask

    task automatic clear_logs();
        log_rd.delete(); log_m.delete(); log_n.delete(); log_last.delete();
        log_cyc.delete(); done_cyc.delete();
    endtask

    task automatic scramble_req();
        req_uuid  = UUID_WIDTH'({$urandom(), $urandom()});
        req_wid   = NW_WIDTH'($urandom());
        req_PC    = PC_BITS'($urandom());
        req_rd    = NUM_REGS_BITS'($urandom());
        req_m_cnt = 4'($urandom()); req_n_cnt = 4'($urandom());
        req_fmt_s = 4'($urandom()); req_fmt_d = 4'($urandom());
        req_scale = 9'($urandom());
    endtask

    task automatic issue_req(input int mc, input int nc, input int rdv, input int scl);
        scramble_req();
        req_m_cnt = 4'(mc); req_n_cnt = 4'(nc);
        req_rd = NUM_REGS_BITS'(rdv); req_scale = 9'(scl);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        scramble_req();
    endtask

    task automatic rand_inputs();
        uop_ready = ($urandom_range(99) < 70);
        retire    = (md_infl > 0) && ($urandom_range(99) < 40);
    endtask

    task automatic settle(input bit need_empty, input int budget);
        int c = 0;
        while ((md_phase != 0 || (need_empty && md_infl != 0)) && c < budget) begin
            rand_inputs();
            step();
            c++;
        end
        if (md_phase != 0 || (need_empty && md_infl != 0)) begin
            n_checks++;
            n_errors++;
            $display("FAIL settle_timeout: got phase %0d inflight %0d after %0d cycles, required idle", md_phase, md_infl, budget);
        end
        uop_ready = 1'b0;
        retire    = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; uop_ready = 1'b0; retire = 1'b0;
        scramble_req();
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_uop_valid", uop_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_scale", scale_combined, 0);

        // 2x2 macro-op with the consumer always ready
        clear_logs();
        issue_req(1, 1, 8, 9'h003);
        uop_ready = 1'b1;
        repeat (6) step();
        uop_ready = 1'b0;
        chk("basic_count", log_rd.size(), 4);
        if (log_rd.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("basic_rd", log_rd[i], 8 + i);
                chk("basic_m", log_m[i], i / 2);
                chk("basic_n", log_n[i], i % 2);
                chk("basic_last", log_last[i], i == 3);
            end
            chk("basic_done_count", done_cyc.size(), 1);
            if (done_cyc.size() == 1) chk("basic_done_cycle", done_cyc[0], log_cyc[3] + 1);
        end

        // Scale change with three micro-ops still in flight
        retire = 1'b1; step(); retire = 1'b0;
        issue_req(0, 1, 20, 9'h1A5);
        chk("drain_valid", uop_valid, 0);
        chk("drain_scale", scale_combined, 9'h003);
        uop_ready = 1'b1;
        retire = 1'b1; step(); retire = 1'b0; step();
        retire = 1'b1; step(); retire = 1'b0;
        chk("drain_scale_mid", scale_combined, 9'h003);
        uop_ready = 1'b0;
        retire = 1'b1; step(); retire = 1'b0;
        chk("drain_scale_last", scale_combined, 9'h003);
        chk("drain_valid_last", uop_valid, 0);
        step();
        chk("drain_scale_new", scale_combined, 9'h1A5);

        // Consumer stall of five cycles in the middle of the sequence
        clear_logs();
        uop_ready = 1'b1; step(); uop_ready = 1'b0;
        repeat (5) step();
        uop_ready = 1'b1; repeat (3) step(); uop_ready = 1'b0;
        chk("stall_count", log_rd.size(), 2);
        if (log_rd.size() == 2) begin
            chk("stall_rd0", log_rd[0], 20);
            chk("stall_rd1", log_rd[1], 21);
            chk("stall_last1", log_last[1], 1);
        end

        // In-flight limit with no retires
        retire = 1'b1; step(); step(); retire = 1'b0;
        clear_logs();
        issue_req(3, 3, 0, 9'h1A5);
        uop_ready = 1'b1;
        repeat (12) step();
        chk("limit_count", log_rd.size(), 8);
        chk("limit_valid", uop_valid, 0);
        retire = 1'b1; step(); retire = 1'b0;
        repeat (4) step();
        chk("limit_one_more", log_rd.size(), 9);
        retire = 1'b1; uop_ready = 1'b0; step();
        uop_ready = 1'b1; retire = 1'b1; step();
        uop_ready = 1'b0; retire = 1'b0;
        chk("same_cycle_count", log_rd.size(), 10);
        chk("same_cycle_valid", uop_valid, 1);
        settle(1, 2000);

        // Degenerate single micro-op
        clear_logs();
        issue_req(0, 0, 5, 9'h1A5);
        uop_ready = 1'b1; repeat (3) step(); uop_ready = 1'b0;
        chk("single_count", log_rd.size(), 1);
        if (log_rd.size() == 1) begin
            chk("single_last", log_last[0], 1);
            chk("single_rd", log_rd[0], 5);
        end
        chk("single_done", done_cyc.size(), 1);

        // Reset in the middle of issuing, then a stray retire
        issue_req(2, 2, 0, 9'h1A5);
        uop_ready = 1'b1; repeat (3) step();
        clear_logs();
        reset = 1'b1; uop_ready = 1'b0; step(); reset = 1'b0;
        chk("midrst_valid", uop_valid, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_scale", scale_combined, 0);
        repeat (3) step();
        chk("midrst_no_done", done_cyc.size(), 0);
        retire = 1'b1; step(); retire = 1'b0;
        chk("underflow_flag", err_underflow, 1);
        chk("underflow_busy", busy, 0);

        // Randomized traffic, including one full 16x16 macro-op
        for (int r = 0; r < 25; r++) begin
            int mc, nc, scl;
            settle(0, 3000);
            repeat ($urandom_range(2)) begin rand_inputs(); step(); end
            mc = (r == 5) ? 15 : int'($urandom_range(3));
            nc = (r == 5) ? 15 : int'($urandom_range(3));
            case ($urandom_range(2))
                0: scl = 9'h1A5;
                1: scl = 9'h003;
                default: scl = int'($urandom_range(511));
            endcase
            rand_inputs();
            issue_req(mc, nc, int'($urandom_range(63)), scl);
        end
        settle(1, 5000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
